diff_manchester_decoder: RTL and testbench
==========================================

// Module: diff_manchester_decoder
// PURPOSE
//  Receive-side differential-Manchester decoder. One line chip (half-bit symbol) per input beat, in tdata[0].
//  Recovers bit alignment from the mandatory mid-bit transition and emits one decoded bit per two chips.
//  Sits after the demodulator/slicer in the RX chain and feeds the framer.
//  Convention: a transition at a bit boundary means 0; no transition means 1. Every bit has a mid-bit transition.
// PARAMETERS
//  C_S00_AXIS_TDATA_WIDTH  32  input stream width; only bit 0 is used
//  C_M00_AXIS_TDATA_WIDTH  32  output stream width; decoded bit is in bit 0, all other bits are 0
//  CNT_W                   16  width of the saturating code-violation counter
// PORTS
//  s00_axis_aclk     in   1      single clock for the block
//  s00_axis_aresetn  in   1      asynchronous, active-low reset
//  s00_axis_tvalid   in   1      input chip valid
//  s00_axis_tdata    in   C_S00  chip level in bit 0
//  s00_axis_tstrb    in   C_S00/8  ignored
//  s00_axis_tlast    in   1      last chip of a frame
//  s00_axis_tready   out  1      input ready
//  m00_axis_tvalid   out  1      decoded bit valid
//  m00_axis_tdata    out  C_M00  {0..., bit}
//  m00_axis_tstrb    out  C_M00/8  constant all ones
//  m00_axis_tlast    out  1      decoded bit ends the frame
//  m00_axis_tready   in   1      downstream ready
//  locked            out  1      state is FIRST or SECOND
//  viol_pulse        out  1      one-cycle pulse per code violation or truncated bit
//  viol_count        out  CNT_W  saturating count of viol_pulse events
// BEHAVIOUR
//  Reset (async, aresetn=0):
//   - state=HUNT, have_prev=0; tvalid, tlast, tdata, viol_pulse and viol_count all 0.
//  Handshakes:
//   - s00_axis_tready = m00_axis_tready | ~m00_axis_tvalid (combinational).
//   - A chip is accepted when tvalid & tready.
//   - Output holds tdata/tlast stable while tvalid=1 & tready=0; tvalid clears on output handshake unless a new bit is loaded that cycle.
//  Registers: prev_chip (last accepted chip), have_prev, first_chip, pending_bit, state.
//  States (all transitions occur only on an accepted chip c; prev_chip<=c always):
//   - HUNT:   if have_prev & c==prev_chip -> the boundary lies before c; pending_bit=1, first_chip=c, go SECOND.
//             Otherwise stay in HUNT.
//   - FIRST:  pending_bit = (c==prev_chip); first_chip=c; go SECOND.
//   - SECOND: if c!=first_chip -> load output (tdata[0]=pending_bit, tvalid=1), go FIRST.
//             If c==first_chip -> code violation: viol_pulse, no output, go HUNT (have_prev=1).
//  Latency: decoded bit is registered the cycle after its second chip is accepted.
//  Bit rate is half the chip rate, so no output stall occurs unless downstream deasserts tready.
//  tlast:
//   - In SECOND with a valid mid transition, the output carries the tlast of the second chip.
//   - Whenever tlast is accepted, next state=HUNT and have_prev=0, clearing alignment between frames.
//   - tlast accepted in HUNT or FIRST, or on a violation: the partial bit is dropped, viol_pulse fires, and no tlast is emitted.
//  viol_count:
//   - Increments on each viol_pulse and saturates at all ones (no wrap).
//   - A violation and a tlast on the same chip count once.
//  Mid-operation reset: immediate clear; any pending output beat is discarded.
// STRUCTURE
//  diff_manchester_pkg: typedef enum logic [1:0] {HUNT, FIRST, SECOND} dm_state_t.
//  No sub-module; one always_comb for next-state/handshake and one always_ff with async reset.
// TESTING
//  1) Chips 0,0,1,1,0,1,0 with tready=1 -> bits 1,1,0 emitted; locked rises after the 2nd chip.
//  2) Lock first, then chips 1,1 in FIRST/SECOND -> viol_pulse=1, viol_count=1, state HUNT, no bit emitted.
//  3) Same stream as (1) with m00_axis_tready low for 5 cycles mid-stream -> s00_axis_tready low; tdata stable; no bit lost or duplicated.
//  4) tlast on the chip that completes bit 3 -> output bit 3 has tlast=1; the next chip restarts in HUNT (have_prev=0).
//  5) tlast on a FIRST chip -> no output beat; viol_pulse=1; next frame decodes correctly.
//  6) aresetn low mid-frame while tvalid=1 -> all outputs 0 the same cycle; re-locks on the next equal chip pair.
//  7) CNT_W=2 with 5 violations -> viol_count saturates at 3.

Source files
------------

// File: rtl/diff_manchester_pkg.sv
// Shared types for the differential-Manchester receive decoder.
package diff_manchester_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } dm_state_t;

endpackage

// File: rtl/diff_manchester_decoder.sv
// Differential-Manchester chip-to-bit decoder with AXI-Stream in/out, lock
// indication and a saturating code-violation counter.
//
// state  | meaning
// HUNT   | no bit alignment; waiting for two equal consecutive chips
// FIRST  | aligned; next chip is the first half of a bit
// SECOND | aligned; next chip must differ from the first half
module diff_manchester_decoder
  import diff_manchester_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int CNT_W                  = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic                                locked,
  output logic                                viol_pulse,
  output logic [CNT_W-1:0]                    viol_count
);

  dm_state_t        state_q, state_d;
  logic             prev_chip_q, prev_chip_d;
  logic             have_prev_q, have_prev_d;
  logic             first_chip_q, first_chip_d;
  logic             pending_bit_q, pending_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             out_last_q, out_last_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic chip;
  logic chip_acc;
  logic unused_inputs;

  assign chip          = s00_axis_tdata[0];
  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1]};

  // State register
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= HUNT;
      prev_chip_q   <= 1'b0;
      have_prev_q   <= 1'b0;
      first_chip_q  <= 1'b0;
      pending_bit_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_last_q    <= 1'b0;
      viol_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      prev_chip_q   <= prev_chip_d;
      have_prev_q   <= have_prev_d;
      first_chip_q  <= first_chip_d;
      pending_bit_q <= pending_bit_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      out_last_q    <= out_last_d;
      viol_q        <= viol_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and handshake
  always_comb begin
    state_d       = state_q;
    prev_chip_d   = prev_chip_q;
    have_prev_d   = have_prev_q;
    first_chip_d  = first_chip_q;
    pending_bit_d = pending_bit_q;
    out_valid_d   = out_valid_q & ~m00_axis_tready;
    out_bit_d     = out_bit_q;
    out_last_d    = out_last_q;
    viol_d        = 1'b0;

    chip_acc = s00_axis_tvalid & s00_axis_tready;

    if (chip_acc) begin
      prev_chip_d = chip;
      have_prev_d = 1'b1;
      unique case (state_q)
        HUNT: begin
          // Equal neighbours can only straddle a bit boundary carrying a 1.
          if (have_prev_q && (chip == prev_chip_q)) begin
            pending_bit_d = 1'b1;
            first_chip_d  = chip;
            state_d       = SECOND;
          end
        end
        FIRST: begin
          pending_bit_d = (chip == prev_chip_q);
          first_chip_d  = chip;
          state_d       = SECOND;
        end
        SECOND: begin
          if (chip != first_chip_q) begin
            out_valid_d = 1'b1;
            out_bit_d   = pending_bit_q;
            out_last_d  = s00_axis_tlast;
            state_d     = FIRST;
          end else begin
            viol_d  = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase

      // Frame end always drops alignment; a partial bit counts as one violation.
      if (s00_axis_tlast) begin
        if ((state_q != SECOND) || (chip == first_chip_q)) viol_d = 1'b1;
        state_d     = HUNT;
        have_prev_d = 1'b0;
      end
    end

    cnt_d = cnt_q;
    if (viol_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs
  assign s00_axis_tready = m00_axis_tready | ~out_valid_q;
  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-1){1'b0}}, out_bit_q};
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tlast  = out_last_q;
  assign locked          = (state_q == FIRST) || (state_q == SECOND);
  assign viol_pulse      = viol_q;
  assign viol_count      = cnt_q;

endmodule

// File: tb/tb_diff_manchester_decoder.sv
// Directed and randomized checks of the differential-Manchester decoder
// against a frame-level pair-reading reference model.
module tb_diff_manchester_decoder;

  localparam int DW = 32;
  typedef logic chq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          s_tvalid, s_tlast, s_tready, s_tready2;
  logic [DW-1:0] s_tdata;
  logic [3:0]    s_tstrb;
  logic          m_tvalid, m_tlast, m_tready, locked, viol_pulse;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tstrb;
  logic [15:0]   viol_count;
  logic          m_tvalid2, m_tlast2, locked2, viol_pulse2;
  logic [DW-1:0] m_tdata2;
  logic [3:0]    m_tstrb2;
  logic [1:0]    viol_count2;

  diff_manchester_decoder #(.CNT_W(16)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
    .locked(locked), .viol_pulse(viol_pulse), .viol_count(viol_count)
  );

  diff_manchester_decoder #(.CNT_W(2)) dut_sat (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready2),
    .m00_axis_tvalid(m_tvalid2), .m00_axis_tdata(m_tdata2), .m00_axis_tstrb(m_tstrb2),
    .m00_axis_tlast(m_tlast2), .m00_axis_tready(m_tready),
    .locked(locked2), .viol_pulse(viol_pulse2), .viol_count(viol_count2)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor: handshakes complete at the following posedge.
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  int            pulse_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      got_data.delete();
      got_last.delete();
      pulse_cnt = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
      end
      if (viol_pulse) pulse_cnt++;
    end
  end

  logic exp_bit[$];
  logic exp_last[$];
  int   exp_viol = 0;
  int   rd_idx   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reads a frame as chip pairs: align on equal neighbours, then each pair must differ.
  task automatic model_frame(input chq_t ch);
    int   n;
    int   p;
    int   a;
    int   b;
    bit   done;
    logic pend;
    n    = ch.size();
    p    = 1;
    done = 0;
    while (!done) begin
      while (p < n && ch[p] != ch[p-1]) p++;
      if (p >= n - 1) begin
        exp_viol++;
        done = 1;
      end else begin
        a    = p;
        pend = 1'b1;
        while (1) begin
          b = a + 1;
          if (ch[b] == ch[a]) begin
            exp_viol++;
            if (b == n - 1) done = 1;
            else p = b + 1;
            break;
          end
          exp_bit.push_back(pend);
          exp_last.push_back(b == n - 1);
          if (b == n - 1) begin done = 1; break; end
          a = b + 1;
          if (a == n - 1) begin exp_viol++; done = 1; break; end
          pend = (ch[a] == ch[b]);
        end
      end
    end
  endtask

  task automatic mk(input logic [15:0] pat, input int n, output chq_t q);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(pat[n-1-i]);
  endtask

  task automatic send_chip(input logic c, input logic last, input bit rnd);
    int cyc;
    bit acc;
    cyc = 0;
    acc = 0;
    s_tvalid = 1'b1;
    s_tdata  = {{(DW-1){1'b0}}, c};
    s_tlast  = last;
    while (!acc && cyc < 200) begin
      if (rnd) m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("chip_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_from(input chq_t q, input int start, input bit rnd);
    for (int i = start; i < q.size(); i++) send_chip(q[i], i == q.size() - 1, rnd);
  endtask

  task automatic drain_and_check(input string tag);
    int ng;
    int ne;
    m_tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ng = got_data.size() - rd_idx;
    ne = exp_bit.size();
    chk({tag, "_nbits"}, 64'(ng), 64'(ne));
    for (int i = 0; i < ng && i < ne; i++) begin
      chk({tag, "_data"}, 64'(got_data[rd_idx+i]), {63'd0, exp_bit[i]});
      chk({tag, "_last"}, {63'd0, got_last[rd_idx+i]}, {63'd0, exp_last[i]});
    end
    rd_idx = got_data.size();
    exp_bit.delete();
    exp_last.delete();
    chk({tag, "_pulses"}, 64'(pulse_cnt), 64'(exp_viol));
    chk({tag, "_vcount"}, 64'(viol_count), 64'(exp_viol));
    chk({tag, "_vsat"}, 64'(viol_count2), 64'((exp_viol > 3) ? 3 : exp_viol));
  endtask

  task automatic gen_frame(output chq_t q);
    int   nb;
    logic lvl;
    logic b;
    int   k;
    q.delete();
    nb  = $urandom_range(1, 6);
    lvl = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) q.push_back(lvl);
    for (int i = 0; i < nb; i++) begin
      b   = 1'($urandom_range(0, 1));
      lvl = b ? lvl : ~lvl;
      q.push_back(lvl);
      lvl = ~lvl;
      q.push_back(lvl);
    end
    if ($urandom_range(0, 5) == 0) begin
      k    = $urandom_range(0, q.size() - 1);
      q[k] = ~q[k];
    end
  endtask

  chq_t q;

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_viol", {63'd0, viol_pulse}, 64'd0);
    chk("rst_vcount", 64'(viol_count), 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd1);
    chk("tstrb_ones", 64'(m_tstrb), 64'hF);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic decode; tlast lands on the chip completing the third bit
    mk(16'h001A, 7, q);
    send_chip(q[0], 1'b0, 0);
    chk("t1_unlocked", {63'd0, locked}, 64'd0);
    send_chip(q[1], 1'b0, 0);
    chk("t1_locked", {63'd0, locked}, 64'd1);
    send_from(q, 2, 0);
    model_frame(q);
    drain_and_check("t1");

    // Previous frame ended on 0; a leading 0 must not lock across frames
    mk(16'h0019, 6, q);
    send_chip(q[0], 1'b0, 0);
    chk("t4_no_carry", {63'd0, locked}, 64'd0);
    send_from(q, 1, 0);
    model_frame(q);
    drain_and_check("t4");

    // Violation in SECOND
    mk(16'h000E, 6, q);
    for (int i = 0; i < 5; i++) send_chip(q[i], 1'b0, 0);
    chk("t2_pulse", {63'd0, viol_pulse}, 64'd1);
    chk("t2_hunt", {63'd0, locked}, 64'd0);
    send_from(q, 5, 0);
    model_frame(q);
    drain_and_check("t2");

    // Downstream stall
    mk(16'h001A, 7, q);
    for (int i = 0; i < 3; i++) send_chip(q[i], 1'b0, 0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {{(DW-1){1'b0}}, q[3]};
    s_tlast  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_s_tready", {63'd0, s_tready}, 64'd0);
      chk("t3_hold_valid", {63'd0, m_tvalid}, 64'd1);
      chk("t3_hold_data", 64'(m_tdata), 64'd1);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_from(q, 3, 0);
    model_frame(q);
    drain_and_check("t3");

    // tlast on a FIRST chip
    mk(16'h000D, 4, q);
    send_from(q, 0, 0);
    chk("t5_pulse", {63'd0, viol_pulse}, 64'd1);
    model_frame(q);
    drain_and_check("t5");

    for (int f = 0; f < 30; f++) begin
      gen_frame(q);
      send_from(q, 0, 1);
      model_frame(q);
      drain_and_check("rnd");
    end

    // Reset mid-frame with a held output beat and a chip on the input
    send_chip(1'b0, 1'b0, 0);
    send_chip(1'b0, 1'b0, 0);
    send_chip(1'b1, 1'b0, 0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'd1;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("t6_tdata", 64'(m_tdata), 64'd0);
    chk("t6_locked", {63'd0, locked}, 64'd0);
    chk("t6_vcount", 64'(viol_count), 64'd0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    exp_bit.delete();
    exp_last.delete();
    exp_viol = 0;
    rd_idx   = 0;
    @(posedge clk);
    #1;
    mk(16'h0019, 5, q);
    send_chip(q[0], 1'b0, 0);
    send_chip(q[1], 1'b0, 0);
    chk("t6_relock", {63'd0, locked}, 64'd1);
    send_from(q, 2, 0);
    model_frame(q);
    drain_and_check("t6");

    // Five violations saturate the 2-bit counter
    mk(16'h0001, 1, q);
    for (int i = 0; i < 5; i++) begin
      send_from(q, 0, 0);
      model_frame(q);
    end
    drain_and_check("t7");
    chk("t7_sat3", 64'(viol_count2), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
